// File: rtl/sdu_seq_ctrl.sv
// Ultrasound TX/RX sequence controller.
// A block of max(num_ave,1) sequences runs from a set of shadowed settings.
// Each sequence is split into TX, guard and RX phases by a phase counter.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | stopped, waiting for a ctrl write with run=1
// S_ARM       | check the settings, load the shadows, start the block
// S_WAIT_TRIG | waiting for a rising edge on ext_trig before the next sequence
// S_SEQ       | phase counter running through TX / guard / RX
module sdu_seq_ctrl #(
   parameter int BASE   = 0,
   parameter int CNT_W  = 32,
   parameter int AVE_W  = 16,
   parameter int NUM_CH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set_stb,
   input  logic [7:0]        set_addr,
   input  logic [31:0]       set_data,
   input  logic              ext_trig,
   output logic [NUM_CH-1:0] tx_en,
   output logic              rx_en,
   output logic              seq_done_strobe,
   output logic              ave_done_strobe,
   output logic [AVE_W-1:0]  seq_index,
   output logic              busy,
   output logic              cfg_err
);

   localparam logic [7:0] A_TX    = 8'(BASE);
   localparam logic [7:0] A_SEQ   = 8'(BASE + 1);
   localparam logic [7:0] A_AVE   = 8'(BASE + 2);
   localparam logic [7:0] A_CTRL  = 8'(BASE + 3);
   localparam logic [7:0] A_GUARD = 8'(BASE + 4);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT_TRIG, S_SEQ} state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0]  tx_len_q, tx_len_d, seq_len_q, seq_len_d, guard_len_q, guard_len_d;
   logic [AVE_W-1:0]  num_ave_q, num_ave_d;
   logic              run_q, run_d, cont_q, cont_d, trig_mode_q, trig_mode_d;
   logic [NUM_CH-1:0] ch_mask_q, ch_mask_d;
   logic              start_req_q, start_req_d, trig_prev_q, trig_prev_d;

   logic [CNT_W-1:0]  tx_s_q, tx_s_d, seq_s_q, seq_s_d, guard_s_q, guard_s_d;
   logic [AVE_W-1:0]  ave_s_q, ave_s_d;
   logic [NUM_CH-1:0] mask_s_q, mask_s_d;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [AVE_W-1:0]  idx_q, idx_d;

   logic [NUM_CH-1:0] tx_en_q, tx_en_d;
   logic              rx_en_q, rx_en_d, seq_done_q, seq_done_d, ave_done_q, ave_done_d;
   logic              busy_q, busy_d, cfg_err_q, cfg_err_d;

   logic              wr_ctrl, abort_wr, trig_rise, cfg_ok, start_blk;
   logic [AVE_W-1:0]  idx_last;
   logic [CNT_W:0]    tx_guard_reg, tx_guard_s;

   // Settings register writes; the start request is delayed one cycle so
   // ARM sees the freshly written registers.
   always_comb begin
      wr_ctrl     = set_stb && (set_addr == A_CTRL);
      abort_wr    = wr_ctrl && set_data[3];
      tx_len_d    = (set_stb && set_addr == A_TX)    ? set_data[CNT_W-1:0] : tx_len_q;
      seq_len_d   = (set_stb && set_addr == A_SEQ)   ? set_data[CNT_W-1:0] : seq_len_q;
      guard_len_d = (set_stb && set_addr == A_GUARD) ? set_data[CNT_W-1:0] : guard_len_q;
      num_ave_d   = (set_stb && set_addr == A_AVE)   ? set_data[AVE_W-1:0] : num_ave_q;
      run_d       = run_q;
      cont_d      = cont_q;
      trig_mode_d = trig_mode_q;
      ch_mask_d   = ch_mask_q;
      if (wr_ctrl) begin
         run_d       = set_data[0] & ~set_data[3];
         cont_d      = set_data[1];
         trig_mode_d = set_data[2];
         ch_mask_d   = set_data[8 +: NUM_CH];
      end
      start_req_d = wr_ctrl && set_data[0] && !set_data[3];
      trig_prev_d = ext_trig;
      trig_rise   = ext_trig && !trig_prev_q;
   end

   // Sequencer next state, counters, shadows and registered output values.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      tx_s_d     = tx_s_q;
      seq_s_d    = seq_s_q;
      guard_s_d  = guard_s_q;
      ave_s_d    = ave_s_q;
      mask_s_d   = mask_s_q;
      cfg_err_d  = cfg_err_q;
      seq_done_d = 1'b0;
      ave_done_d = 1'b0;
      start_blk  = 1'b0;
      tx_en_d    = '0;
      rx_en_d    = 1'b0;

      tx_guard_reg = {1'b0, tx_len_q} + {1'b0, guard_len_q};
      cfg_ok       = (seq_len_q != '0) && (tx_guard_reg < {1'b0, seq_len_q});
      idx_last     = (ave_s_q == '0) ? '0 : ave_s_q - AVE_W'(1);

      case (state_q)
         S_IDLE: begin
            idx_d = '0;
            if (start_req_q) state_d = S_ARM;
         end
         S_ARM: start_blk = 1'b1;
         S_WAIT_TRIG: begin
            if (!run_q) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else if (trig_rise) begin
               state_d = S_SEQ;
               cnt_d   = '0;
            end
         end
         S_SEQ: begin
            if (cnt_q == seq_s_q - CNT_W'(1)) begin
               seq_done_d = 1'b1;
               cnt_d      = '0;
               if (idx_q == idx_last) begin
                  ave_done_d = 1'b1;
                  idx_d      = '0;
                  if (cont_q && run_q) start_blk = 1'b1;
                  else                 state_d   = S_IDLE;
               end else if (!run_q) begin
                  state_d = S_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d   = idx_q + AVE_W'(1);
                  state_d = trig_mode_q ? S_WAIT_TRIG : S_SEQ;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Block start shared by ARM and continuous re-arm.
      if (start_blk) begin
         cnt_d = '0;
         if (cfg_ok) begin
            cfg_err_d = 1'b0;
            tx_s_d    = tx_len_q;
            seq_s_d   = seq_len_q;
            guard_s_d = guard_len_q;
            ave_s_d   = num_ave_q;
            mask_s_d  = ch_mask_q;
            state_d   = trig_mode_q ? S_WAIT_TRIG : S_SEQ;
         end else begin
            cfg_err_d = 1'b1;
            state_d   = S_IDLE;
         end
      end

      if (abort_wr) begin
         state_d    = S_IDLE;
         cnt_d      = '0;
         idx_d      = '0;
         seq_done_d = 1'b0;
         ave_done_d = 1'b0;
      end

      // Outputs are decoded from the next state so they line up with it.
      tx_guard_s = {1'b0, tx_s_d} + {1'b0, guard_s_d};
      if (state_d == S_SEQ) begin
         if (cnt_d < tx_s_d)                      tx_en_d = mask_s_d;
         else if ({1'b0, cnt_d} >= tx_guard_s)    rx_en_d = 1'b1;
      end
      busy_d = (state_d != S_IDLE);
   end

   // All state, settings and output registers; synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         tx_len_q    <= '0;
         seq_len_q   <= '0;
         guard_len_q <= '0;
         num_ave_q   <= '0;
         run_q       <= 1'b0;
         cont_q      <= 1'b0;
         trig_mode_q <= 1'b0;
         ch_mask_q   <= '0;
         start_req_q <= 1'b0;
         trig_prev_q <= 1'b0;
         tx_s_q      <= '0;
         seq_s_q     <= '0;
         guard_s_q   <= '0;
         ave_s_q     <= '0;
         mask_s_q    <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         tx_en_q     <= '0;
         rx_en_q     <= 1'b0;
         seq_done_q  <= 1'b0;
         ave_done_q  <= 1'b0;
         busy_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_len_q    <= tx_len_d;
         seq_len_q   <= seq_len_d;
         guard_len_q <= guard_len_d;
         num_ave_q   <= num_ave_d;
         run_q       <= run_d;
         cont_q      <= cont_d;
         trig_mode_q <= trig_mode_d;
         ch_mask_q   <= ch_mask_d;
         start_req_q <= start_req_d;
         trig_prev_q <= trig_prev_d;
         tx_s_q      <= tx_s_d;
         seq_s_q     <= seq_s_d;
         guard_s_q   <= guard_s_d;
         ave_s_q     <= ave_s_d;
         mask_s_q    <= mask_s_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         tx_en_q     <= tx_en_d;
         rx_en_q     <= rx_en_d;
         seq_done_q  <= seq_done_d;
         ave_done_q  <= ave_done_d;
         busy_q      <= busy_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign tx_en           = tx_en_q;
   assign rx_en           = rx_en_q;
   assign seq_done_strobe = seq_done_q;
   assign ave_done_strobe = ave_done_q;
   assign seq_index       = idx_q;
   assign busy            = busy_q;
   assign cfg_err         = cfg_err_q;

endmodule

// File: doc/sdu_seq_ctrl.md
Name: sdu_seq_ctrl

Overview:
- Parametrised ultrasound sequence controller; next generation of the single-channel TX/RX sequencer.
- Drives per-channel TX enables, a guard (dead-time) interval, RX enable, sequence/average strobes and a sequence index for the DSP chain.
- Adds run/stop/abort control, single-shot or continuous operation, optional external trigger per sequence, config shadowing and config-error detection.
- Configured through the settings bus (set_stb/set_addr/set_data).

Parameters:
- BASE, 0, first settings address; uses BASE+0..BASE+4.
- CNT_W, 32, width of length registers and the phase counter.
- AVE_W, 16, width of num_ave and seq_index.
- NUM_CH, 4, number of TX enable outputs (1..16).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- ext_trig  in  1  external trigger, synchronous to clk; rising edge is detected internally.
- tx_en  out  NUM_CH  per-channel transmit enable.
- rx_en  out  1  receive window.
- seq_done_strobe  out  1  one-cycle pulse at the end of each sequence.
- ave_done_strobe  out  1  one-cycle pulse at the end of each averaging block.
- seq_index  out  AVE_W  index of the current sequence within the block.
- busy  out  1  high whenever not IDLE.
- cfg_err  out  1  sticky config error.

Behaviour:
- Settings registers:
  - BASE+0 tx_len.
  - BASE+1 seq_len.
  - BASE+2 num_ave.
  - BASE+3 ctrl: bit0 run, bit1 continuous, bit2 trig_mode, bit3 abort, bits[8+NUM_CH-1:8] ch_mask.
  - BASE+4 guard_len.
  - All registers reset to 0.
- Shadowing:
  - tx_len, seq_len, guard_len, num_ave and ch_mask are copied into shadows when a block starts.
  - Writes during a block take effect only at the next block start.
- num_ave=0 is treated as 1. A block is exactly max(num_ave,1) sequences.
- States: IDLE, ARM, WAIT_TRIG, SEQ.
- Phase counter within SEQ runs 0..seq_len-1:
  - TX phase: cnt < tx_len; tx_en = ch_mask, rx_en = 0.
  - GUARD phase: tx_len <= cnt < tx_len+guard_len; all enables 0.
  - RX phase: otherwise; rx_en = 1.
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, counters 0.
- Start and run latency:
  - IDLE→ARM on the cycle a ctrl write with run=1 and abort=0 is registered.
  - ARM validates the shadows:
    - If seq_len == 0, or tx_len+guard_len >= seq_len (CNT_W+1-bit compare), set cfg_err and return to IDLE.
    - Otherwise go to SEQ, or to WAIT_TRIG if trig_mode=1.
  - Without trigger, tx_en is high in the 3rd cycle after the set_stb cycle and stays high exactly tx_len cycles.
  - tx_len=0 means no TX cycles.
- WAIT_TRIG: all enables 0. A rising edge of ext_trig moves to SEQ, cnt=0, on the next cycle. In trig_mode every sequence waits for its own edge.
- End of sequence (cnt == seq_len-1):
  - seq_done_strobe pulses in the following cycle, together with the first cycle of the next sequence or IDLE.
  - If seq_index == max(num_ave,1)-1: ave_done_strobe pulses in the same cycle and seq_index wraps to 0. Otherwise seq_index increments.
- After a block completes:
  - If continuous=1 and run=1, re-shadow and start the next block with no idle cycle (trig_mode still waits for a trigger).
  - Otherwise go to IDLE. Single-shot re-arms only on a new ctrl write with run=1.
- Stop: run cleared mid-block completes the current sequence with its strobes, then goes to IDLE. The block is not completed.
- Abort: a ctrl write with abort=1 forces IDLE the next cycle. All enables go low, no strobes, seq_index=0. abort has priority over run in the same write.
- tx_en and rx_en are never high in the same cycle.
- cfg_err is cleared by any ctrl write with run=1 that passes validation.
- Reset mid-operation returns everything to reset values in one cycle.

Test Plan:
- tx_len=3, guard_len=2, seq_len=10, num_ave=2, ch_mask=4'b0101, run=1 -> per sequence: tx_en=0101 for 3 cycles, 2 guard cycles, rx_en for 5 cycles. seq_done pulses twice, ave_done once with the 2nd seq_done, seq_index 0,1,0. Then IDLE, busy=0.
- Same config with continuous=1, num_ave=0 -> every sequence is a block (ave_done with each seq_done), no gap between sequences. Write run=0 mid-RX -> current sequence finishes, then IDLE.
- trig_mode=1, ext_trig pulses 20 cycles apart, seq_len=8 -> each TX starts exactly 1 cycle after each rising edge. A held-high ext_trig starts no extra sequences.
- tx_len=5, guard_len=5, seq_len=10 -> cfg_err=1, no enables ever asserted. Rewrite seq_len=11, run=1 -> cfg_err clears, normal sequencing.
- Mid-TX write seq_len=20 -> current block keeps the old seq_len, next block uses 20. Write abort=1 during TX -> tx_en=0 next cycle, no strobes, seq_index=0.
- Assert reset during RX -> all outputs 0 next cycle. tx_len=0 -> first enabled cycle is guard or RX, tx_en never high.
